alu_funct_exec: RTL and testbench

Parametrised successor to the processor's ALU-control decode. Takes `ALUop`/`Funct` plus operands, decodes the extended R-type set and executes it. Single-cycle ops give a registered result; MULT/MULTU/DIV/DIVU run on an iterative unit that writes HI/LO, with a start/busy/done handshake the multicycle control FSM waits on. Sits in the EX stage between the register-file A/B latches and ALUOut.

---
 rtl/alu_pkg.sv | 55 +++++
 rtl/alu_muldiv_seq.sv | 115 +++++++++++
 rtl/alu_funct_exec.sv | 181 ++++++++++++++++++
 tb/tb_alu_funct_exec.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared encodings for the EX-stage ALU with ALU-control decode.
//   - ALUop encodings and R-type funct codes
//   - FSM state encoding (IDLE / MUL / DIV / FIX)
//   - internal operation enum produced by the funct decode
//   - is_muldiv(): true for ops that run on the iterative unit
package alu_pkg;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_NOR,
    OP_SLT,
    OP_SLTU,
    OP_MFHI,
    OP_MFLO,
    OP_MULT,
    OP_MULTU,
    OP_DIV,
    OP_DIVU,
    OP_ILL
  } op_t;

  function automatic logic is_muldiv(input op_t op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: iterative multiply/divide datapath.
//   Radix-2 shift-add multiply and restoring divide, one bit per step,
//   sharing a single 2*WIDTH working register. Operands are captured as
//   magnitudes on 'load'; the sign fix is applied combinationally on
//   hi/lo, which the parent registers in its FIX state.
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   load          capture operands and operation (one cycle)
//   is_div        1 = div/divu, 0 = mult/multu (sampled on load)
//   is_signed     1 = signed variant (sampled on load)
//   a, b          operands (sampled on load)
//   step          perform one iteration this cycle
//   last          current step is the final (WIDTH-th) iteration
//   hi, lo        sign-corrected results (valid once iterations finish)
module alu_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             step,
  output logic             last,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  // prod holds {partial product, multiplier} for mult and
  // {remainder, dividend/quotient} for div.
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   mcand;
  logic [CW-1:0]      cnt;
  logic               div_q;
  logic               neg_hi;
  logic               neg_lo;
  logic               dvz;

  logic               sa;
  logic               sb;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  assign sa    = is_signed & a[WIDTH-1];
  assign sb    = is_signed & b[WIDTH-1];
  assign a_mag = sa ? -a : a;
  assign b_mag = sb ? -b : b;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] prod_next;

  always_comb begin
    sum       = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    shifted   = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
    trial     = shifted - {1'b0, mcand};
    prod_next = prod;
    if (div_q) begin
      // trial[WIDTH] set means the subtraction borrowed: restore.
      if (!trial[WIDTH]) prod_next = {trial[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};
      else               prod_next = {shifted[WIDTH-1:0], prod[WIDTH-2:0], 1'b0};
    end else begin
      prod_next = {sum, prod[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prod   <= '0;
      mcand  <= '0;
      cnt    <= '0;
      div_q  <= 1'b0;
      neg_hi <= 1'b0;
      neg_lo <= 1'b0;
      dvz    <= 1'b0;
    end else if (load) begin
      // Multiplier and dividend both occupy the low half.
      prod   <= {{WIDTH{1'b0}}, is_div ? a_mag : b_mag};
      mcand  <= is_div ? b_mag : a_mag;
      cnt    <= '0;
      div_q  <= is_div;
      neg_lo <= sa ^ sb;
      neg_hi <= is_div ? sa : (sa ^ sb);
      dvz    <= is_div && (b == '0);
    end else if (step) begin
      prod <= prod_next;
      cnt  <= cnt + CW'(1);
    end
  end

  assign last = (cnt == CW'(WIDTH - 1));

  logic [2*WIDTH-1:0] prod_neg;
  assign prod_neg = -prod;

  always_comb begin
    hi = '0;
    lo = '0;
    if (div_q) begin
      // Remainder follows dividend sign; divide-by-zero forces an all-ones
      // quotient while the remainder path already yields the dividend.
      hi = neg_hi ? -prod[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
      lo = dvz ? '1 : (neg_lo ? -prod[WIDTH-1:0] : prod[WIDTH-1:0]);
    end else begin
      hi = neg_hi ? prod_neg[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
      lo = neg_lo ? prod_neg[WIDTH-1:0]       : prod[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/alu_funct_exec.sv
// alu_funct_exec: EX-stage ALU with integrated ALUop/funct decode.
//   Single-cycle ops produce a registered result with a one-cycle done
//   pulse. mult/multu/div/divu run on alu_muldiv_seq and write HI/LO.
//   Build option: define ALU_MULDIV_EN to build the iterative unit;
//   otherwise those functs decode as illegal, busy is 0, hi/lo stay 0.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start             operation request (accepted only in IDLE)
//   alu_op[1:0]       00 add, 01 sub, 1x decode funct
//   funct[5:0]        R-type function field
//   a, b              operands
//   result, zero      registered result and result==0 flag
//   hi, lo            HI/LO architectural registers
//   busy              iterative op in progress
//   done              one-cycle completion pulse
//   illegal           one-cycle pulse with done for an undefined funct
module alu_funct_exec
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             illegal
);

  op_t              op;
  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             zero_q;
  logic             done_q;
  logic             ill_q;
  logic             accept;
  logic             md_last;
  logic [WIDTH-1:0] md_hi;
  logic [WIDTH-1:0] md_lo;

  always_comb begin
    op = OP_ILL;
    if (alu_op == ALUOP_ADD) begin
      op = OP_ADD;
    end else if (alu_op == ALUOP_SUB) begin
      op = OP_SUB;
    end else begin
      case (funct)
        FN_ADD:   op = OP_ADD;
        FN_SUB:   op = OP_SUB;
        FN_AND:   op = OP_AND;
        FN_OR:    op = OP_OR;
        FN_XOR:   op = OP_XOR;
        FN_NOR:   op = OP_NOR;
        FN_SLT:   op = OP_SLT;
        FN_SLTU:  op = OP_SLTU;
        FN_MFHI:  op = OP_MFHI;
        FN_MFLO:  op = OP_MFLO;
`ifdef ALU_MULDIV_EN
        FN_MULT:  op = OP_MULT;
        FN_MULTU: op = OP_MULTU;
        FN_DIV:   op = OP_DIV;
        FN_DIVU:  op = OP_DIVU;
`endif
        default:  op = OP_ILL;
      endcase
    end
  end

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_NOR:  alu_res = ~(a | b);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_MFHI: alu_res = hi_q;
      OP_MFLO: alu_res = lo_q;
      default: alu_res = '0;
    endcase
  end

  assign accept = start && (state_q == ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && (op == OP_MULT || op == OP_MULTU)) state_d = ST_MUL;
        else if (accept && (op == OP_DIV || op == OP_DIVU)) state_d = ST_DIV;
      end
      ST_MUL,
      ST_DIV:  if (md_last) state_d = ST_FIX;
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef ALU_MULDIV_EN
  alu_muldiv_seq #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk      (clk),
    .reset    (reset),
    .load     (accept && is_muldiv(op)),
    .is_div   (op == OP_DIV || op == OP_DIVU),
    .is_signed(op == OP_MULT || op == OP_DIV),
    .a        (a),
    .b        (b),
    .step     (state_q == ST_MUL || state_q == ST_DIV),
    .last     (md_last),
    .hi       (md_hi),
    .lo       (md_lo)
  );

  assign busy = (state_q != ST_IDLE);
`else
  assign md_last = 1'b0;
  assign md_hi   = '0;
  assign md_lo   = '0;
  assign busy    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
      zero_q   <= 1'b1;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      ill_q  <= 1'b0;
      if (accept) begin
        if (op == OP_ILL) begin
          done_q <= 1'b1;
          ill_q  <= 1'b1;
        end else if (!is_muldiv(op)) begin
          result_q <= alu_res;
          zero_q   <= (alu_res == '0);
          done_q   <= 1'b1;
        end
      end
      if (state_q == ST_FIX) begin
        hi_q   <= md_hi;
        lo_q   <= md_lo;
        done_q <= 1'b1;
      end
    end
  end

  assign result  = result_q;
  assign zero    = zero_q;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign done    = done_q;
  assign illegal = ill_q;

endmodule

// File: tb/tb_alu_funct_exec.sv
// tb_alu_funct_exec: scoreboard bench for alu_funct_exec (WIDTH=32).
// Expected results are computed by a behavioural model when an operation
// is issued and compared when done pulses. Follows ALU_MULDIV_EN: with it
// defined the iterative ops are exercised, otherwise they must decode as
// illegal (also checked on a WIDTH=8 instance).
module tb_alu_funct_exec;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   alu_op;
  logic [5:0]   funct;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [W-1:0] result;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         zero;
  logic         busy;
  logic         done;
  logic         illegal;

  always #5 clk = ~clk;

  alu_funct_exec #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .alu_op(alu_op), .funct(funct),
    .a(op_a), .b(op_b), .result(result), .zero(zero), .hi(hi), .lo(lo),
    .busy(busy), .done(done), .illegal(illegal)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    string        tag;
    logic [W-1:0] res;
    logic         z;
    logic [W-1:0] h;
    logic [W-1:0] l;
    logic         ill;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] m_res = '0;
  logic [W-1:0] m_hi  = '0;
  logic [W-1:0] m_lo  = '0;

  function automatic exp_t model(input logic [1:0] op, input logic [5:0] f,
                                 input logic [W-1:0] x, input logic [W-1:0] y,
                                 input string tag);
    exp_t         e;
    logic         ill = 1'b0;
    logic         wr  = 1'b1;
    logic [W-1:0] r   = '0;
    logic [W-1:0] mn  = {1'b1, {(W-1){1'b0}}};
    logic [2*W-1:0] p;
    if (op == 2'b00) r = x + y;
    else if (op == 2'b01) r = x - y;
    else begin
      case (f)
        6'b100000: r = x + y;
        6'b100010: r = x - y;
        6'b100100: r = x & y;
        6'b100101: r = x | y;
        6'b100110: r = x ^ y;
        6'b100111: r = ~(x | y);
        6'b101010: r = ($signed(x) < $signed(y)) ? 1 : 0;
        6'b101011: r = (x < y) ? 1 : 0;
        6'b010000: r = m_hi;
        6'b010010: r = m_lo;
`ifdef ALU_MULDIV_EN
        6'b011000: begin
          wr = 1'b0;
          p = {{W{x[W-1]}}, x} * {{W{y[W-1]}}, y};
          {m_hi, m_lo} = p;
        end
        6'b011001: begin
          wr = 1'b0;
          p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
          {m_hi, m_lo} = p;
        end
        6'b011010: begin
          wr = 1'b0;
          if (y == '0) begin m_lo = '1; m_hi = x; end
          else if (x == mn && y == '1) begin m_lo = mn; m_hi = '0; end
          else begin m_lo = $signed(x) / $signed(y); m_hi = $signed(x) % $signed(y); end
        end
        6'b011011: begin
          wr = 1'b0;
          if (y == '0) begin m_lo = '1; m_hi = x; end
          else begin m_lo = x / y; m_hi = x % y; end
        end
`endif
        default: ill = 1'b1;
      endcase
    end
    if (ill) wr = 1'b0;
    if (wr) m_res = r;
    e.tag = tag; e.res = m_res; e.z = (m_res == '0);
    e.h = m_hi; e.l = m_lo; e.ill = ill;
    return e;
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest issued op.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'(done), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.tag, "_result"},  64'(result),  64'(e.res));
        check({e.tag, "_zero"},    64'(zero),    64'(e.z));
        check({e.tag, "_hi"},      64'(hi),      64'(e.h));
        check({e.tag, "_lo"},      64'(lo),      64'(e.l));
        check({e.tag, "_illegal"}, 64'(illegal), 64'(e.ill));
      end
    end
    if (!reset && illegal && !done) check("illegal_without_done", 64'(illegal), 64'd0);
  end

  task automatic run_op(input logic [1:0] op, input logic [5:0] f,
                        input logic [W-1:0] x, input logic [W-1:0] y,
                        input string tag, input int lat);
    int cycles = 0;
    logic got = 1'b0;
    @(negedge clk);
    alu_op = op; funct = f; op_a = x; op_b = y; start = 1'b1;
    sb.push_back(model(op, f, x, y, tag));
    @(posedge clk);
    #1 start = 1'b0;
    while (!got && cycles < 200) begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) check({tag, "_busy_start"}, 64'(busy), 64'(lat > 1));
      if (done) got = 1'b1;
    end
    check({tag, "_latency"}, 64'(cycles), 64'(lat));
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
  endtask

`ifndef ALU_MULDIV_EN
  logic [7:0] r8, h8, l8;
  logic       z8, busy8, done8, ill8, start8;
  alu_funct_exec #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .alu_op(2'b10), .funct(6'b011001),
    .a(8'd13), .b(8'd11), .result(r8), .zero(z8), .hi(h8), .lo(l8),
    .busy(busy8), .done(done8), .illegal(ill8)
  );
`endif

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] fl[8];
    fl[0] = 6'b100000; fl[1] = 6'b100010; fl[2] = 6'b100100; fl[3] = 6'b100101;
    fl[4] = 6'b100110; fl[5] = 6'b100111; fl[6] = 6'b101010; fl[7] = 6'b101011;
    reset = 1'b1; start = 1'b0; alu_op = '0; funct = '0; op_a = '0; op_b = '0;
`ifndef ALU_MULDIV_EN
    start8 = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_result",  64'(result),  64'd0);
    check("rst_zero",    64'(zero),    64'd1);
    check("rst_hi",      64'(hi),      64'd0);
    check("rst_lo",      64'(lo),      64'd0);
    check("rst_busy",    64'(busy),    64'd0);
    check("rst_done",    64'(done),    64'd0);
    check("rst_illegal", 64'(illegal), 64'd0);

    run_op(2'b01, 6'b000000, 32'd5, 32'd7, "sub_op", 1);
    run_op(2'b00, 6'b000000, 32'd1, 32'hFFFF_FFFF, "add_zero", 1);
    run_op(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1, "slt", 1);
    run_op(2'b10, 6'b101011, 32'hFFFF_FFFF, 32'd1, "sltu", 1);
    run_op(2'b11, 6'b100111, 32'h0F0F_0000, 32'h0000_00F0, "nor_op11", 1);
    run_op(2'b10, 6'b100100, 32'hDEAD_BEEF, 32'hFF00_FF00, "and", 1);
    run_op(2'b10, 6'b111111, 32'd3, 32'd4, "illegal_fn", 1);
    run_op(2'b10, 6'b010000, 32'd0, 32'd0, "mfhi0", 1);

    // Back-to-back single-cycle ops, start held high across edges.
    for (int i = 0; i < 12; i++) begin
      logic [1:0] o;
      logic [5:0] f;
      logic [W-1:0] x, y;
      @(negedge clk);
      o = (i % 4 == 0) ? 2'(i % 8 / 4) : 2'b10;
      f = fl[$urandom_range(0, 7)];
      x = $urandom; y = (i == 5) ? x : $urandom;
      alu_op = o; funct = f; op_a = x; op_b = y; start = 1'b1;
      sb.push_back(model(o, f, x, y, $sformatf("b2b%0d", i)));
    end
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);

`ifdef ALU_MULDIV_EN
    run_op(2'b10, 6'b011000, -32'sd3, 32'd7, "mult", W + 1);
    run_op(2'b10, 6'b010010, 32'd0, 32'd0, "mflo", 1);
    run_op(2'b10, 6'b010000, 32'd0, 32'd0, "mfhi", 1);
    run_op(2'b10, 6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu", W + 1);
    run_op(2'b10, 6'b011010, -32'sd7, 32'd2, "div_neg", W + 1);
    run_op(2'b10, 6'b011010, 32'd7, -32'sd2, "div_negb", W + 1);
    run_op(2'b10, 6'b011011, 32'd9, 32'd0, "divu_zero", W + 1);
    run_op(2'b10, 6'b011010, -32'sd9, 32'd0, "div_zero", W + 1);
    run_op(2'b10, 6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, "div_min", W + 1);
    run_op(2'b10, 6'b011011, 32'hFFFF_FFF0, 32'd7, "divu", W + 1);

    // start while busy must be ignored.
    begin
      int cycles = 0;
      @(negedge clk);
      alu_op = 2'b10; funct = 6'b011000; op_a = 32'd123; op_b = -32'sd45; start = 1'b1;
      sb.push_back(model(2'b10, 6'b011000, 32'd123, -32'sd45, "mult_busy"));
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(negedge clk);
      check("busy_mid", 64'(busy), 64'd1);
      alu_op = 2'b00; op_a = 32'd1; op_b = 32'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (!done && cycles < 100) begin
        @(negedge clk);
        cycles++;
      end
      check("busy_ignore_done_seen", 64'(done), 64'd1);
      repeat (3) @(negedge clk);
    end

    // Reset during iteration 10 aborts and clears HI/LO.
    @(negedge clk);
    alu_op = 2'b10; funct = 6'b011000; op_a = 32'd77; op_b = 32'd99; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(negedge clk);
    check("rst_mid_busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    m_res = '0; m_hi = '0; m_lo = '0;
    @(negedge clk);
    check("rst_mid_busy",   64'(busy),   64'd0);
    check("rst_mid_hi",     64'(hi),     64'd0);
    check("rst_mid_lo",     64'(lo),     64'd0);
    check("rst_mid_done",   64'(done),   64'd0);
    check("rst_mid_result", 64'(result), 64'd0);
    check("rst_mid_zero",   64'(zero),   64'd1);
    repeat (40) @(negedge clk);
    run_op(2'b10, 6'b010010, 32'd0, 32'd0, "mflo_after_rst", 1);
`else
    run_op(2'b10, 6'b011000, -32'sd3, 32'd7, "mult_disabled", 1);
    run_op(2'b10, 6'b011011, 32'd9, 32'd0, "divu_disabled", 1);
    run_op(2'b10, 6'b010000, 32'd0, 32'd0, "mfhi_disabled", 1);

    // WIDTH=8 instance: multu must pulse illegal with done, never busy.
    @(negedge clk);
    start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    @(negedge clk);
    check("w8_done",    64'(done8), 64'd1);
    check("w8_illegal", 64'(ill8),  64'd1);
    check("w8_busy",    64'(busy8), 64'd0);
    check("w8_hi",      64'(h8),    64'd0);
    check("w8_lo",      64'(l8),    64'd0);
    check("w8_result",  64'(r8),    64'd0);
    check("w8_zero",    64'(z8),    64'd1);
    @(negedge clk);
    check("w8_done_pulse", 64'(done8), 64'd0);
    check("w8_busy_after", 64'(busy8), 64'd0);
`endif

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
